io_bist: RTL and testbench

Parametrised built-in self-test sequencer for the `tt_um_*` user-project boundary. It sits between the harness and the design under test.
- On `start`, it drives a pseudo-random stimulus vector every cycle onto the DUT's dedicated inputs.
- It compresses the DUT outputs into a 16-bit MISR signature, accounting for a configurable DUT pipeline latency.
- The same sequence can run on silicon and in the cocotb bench, so both are checked with one golden signature.

---
 rtl/io_bist.sv | 122 ++++++++++++
 tb/tb_io_bist.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/io_bist.sv
// io_bist: LFSR stimulus / MISR signature BIST sequencer for a tt_um_* DUT.
// Optional golden-signature comparator: define IO_BIST_COMPARE_EN.
module io_bist #(
   parameter int          IN_W         = 8,
   parameter int          OUT_W        = 8,
   parameter int          NUM_VECTORS  = 256,
   parameter int          LATENCY      = 1,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter logic [15:0] EXPECTED_SIG = 16'h0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OUT_W-1:0] dut_out,
   output logic [IN_W-1:0]  stim,
   output logic             dut_ena,
   output logic             busy,
   output logic             done,
   output logic [15:0]      signature,
   output logic             pass
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam logic [15:0] LAST_RUN   = 16'(NUM_VECTORS - 1);
   localparam logic [15:0] LAST_DRAIN = 16'(NUM_VECTORS + LATENCY - 1);
   localparam logic [16:0] LAT        = 17'(LATENCY);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;
   logic [15:0] misr;
   logic [15:0] misr_nxt;
   logic [15:0] cnt;
   logic        go;
   logic        capture;

   function automatic logic [15:0] step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   assign go       = start && (state == IDLE || state == DONE);
   assign lfsr_nxt = step(lfsr);
   assign misr_nxt = step(misr) ^ 16'(dut_out);

   // Capture once the pipeline has filled: cnt >= LATENCY, written
   // as cnt+1 > LATENCY so it stays meaningful when LATENCY is 0.
   assign capture = busy && (({1'b0, cnt} + 17'd1) > LAT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      dut_ena   = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            dut_ena = 1'b1;
            if (cnt == LAST_RUN)
               state_nxt = (LATENCY == 0) ? DONE : DRAIN;
         end
         DRAIN: begin
            busy    = 1'b1;
            dut_ena = 1'b1;
            if (cnt == LAST_DRAIN) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // LFSR, MISR, cycle counter and registered stimulus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
         misr <= 16'h0000;
         cnt  <= 16'h0000;
         stim <= '0;
      end else if (go) begin
         lfsr <= LFSR_SEED;
         misr <= 16'h0000;
         cnt  <= 16'h0000;
         stim <= LFSR_SEED[IN_W-1:0];
      end else begin
         if (state == RUN) begin
            lfsr <= lfsr_nxt;
            stim <= (cnt == LAST_RUN) ? '0 : lfsr_nxt[IN_W-1:0];
         end
         if (busy)    cnt  <= cnt + 16'd1;
         if (capture) misr <= misr_nxt;
      end
   end

   assign signature = misr;

`ifdef IO_BIST_COMPARE_EN
   assign pass = done && (signature == EXPECTED_SIG);
`else
   // No comparator: the constant AND removes it; software checks signature.
   assign pass = 1'b0 & (signature == EXPECTED_SIG);
`endif

endmodule

// File: tb/tb_io_bist.sv
// tb_io_bist: directed bench for io_bist across several parameter sets.
// Golden values are hand-computed constants or from a small reference model.
module tb_io_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a;
   logic        start_b;
   logic [7:0]  stim [5];
   logic [4:0]  ena;
   logic [4:0]  busy;
   logic [4:0]  done;
   logic [4:0]  pass;
   logic [15:0] sig [5];

   logic [7:0]  d0  = 8'h00;
   logic [7:0]  d3a = 8'h00;
   logic [7:0]  d3b = 8'h00;

   int n_chk  = 0;
   int n_pass = 0;

   // Model DUTs: u0 identity with one register, u3 identity with two.
   always @(posedge clk) begin
      d0  <= stim[0];
      d3a <= stim[3];
      d3b <= d3a;
   end

   io_bist u0 (
      .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(d0),
      .stim(stim[0]), .dut_ena(ena[0]), .busy(busy[0]),
      .done(done[0]), .signature(sig[0]), .pass(pass[0])
   );

   io_bist #(.NUM_VECTORS(1), .LATENCY(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(8'h5A),
      .stim(stim[1]), .dut_ena(ena[1]), .busy(busy[1]),
      .done(done[1]), .signature(sig[1]), .pass(pass[1])
   );

   io_bist #(.NUM_VECTORS(2), .LATENCY(0), .EXPECTED_SIG(16'h00EE)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(8'h5A),
      .stim(stim[2]), .dut_ena(ena[2]), .busy(busy[2]),
      .done(done[2]), .signature(sig[2]), .pass(pass[2])
   );

   io_bist #(.NUM_VECTORS(16), .LATENCY(2)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(d3b),
      .stim(stim[3]), .dut_ena(ena[3]), .busy(busy[3]),
      .done(done[3]), .signature(sig[3]), .pass(pass[3])
   );

   io_bist #(.NUM_VECTORS(16), .LATENCY(0)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(stim[4]),
      .stim(stim[4]), .dut_ena(ena[4]), .busy(busy[4]),
      .done(done[4]), .signature(sig[4]), .pass(pass[4])
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] adv(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [7:0] vec(input int k);
      logic [15:0] l;
      l = 16'hACE1;
      for (int i = 0; i < k; i++) l = adv(l);
      return l[7:0];
   endfunction

   // Signature of an identity DUT over n vectors.
   function automatic logic [15:0] model(input int n);
      logic [15:0] l;
      logic [15:0] s;
      l = 16'hACE1;
      s = 16'h0000;
      for (int k = 0; k < n; k++) begin
         s = adv(s) ^ {8'h00, l[7:0]};
         l = adv(l);
      end
      return s;
   endfunction

   // Wait for u0 done; t is the cycle number, -1 on timeout.
   task automatic run_to_done(input int from, output int t);
      t = -1;
      for (int c = from + 1; c <= from + 400; c++) begin
         @(negedge clk);
         if (done[0]) begin
            t = c;
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] exp16;
      logic [15:0] exp256;
      logic        exp_p2;
      logic        exp_p0;
      int          t;
      int          t1, t2, t3, t4;
      logic [15:0] s1, s2, s3, s4;
      logic        p2;

      exp16  = model(16);
      exp256 = model(256);
`ifdef IO_BIST_COMPARE_EN
      exp_p2 = 1'b1;
      exp_p0 = (exp256 == 16'h0000);
`else
      exp_p2 = 1'b0;
      exp_p0 = 1'b0;
`endif

      rst_n   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_stim", 32'(stim[0]), 32'h0);
      check("rst_flags", 32'({ena[0], busy[0], done[0], pass[0]}), 32'h0);
      check("rst_sig", 32'(sig[0]), 32'h0);
      rst_n = 1'b1;

      // Small configurations run together
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      t1 = -1; t2 = -1; t3 = -1; t4 = -1;
      s1 = '0; s2 = '0; s3 = '0; s4 = '0; p2 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done[1] && t1 < 0) begin t1 = c; s1 = sig[1]; end
         if (done[2] && t2 < 0) begin t2 = c; s2 = sig[2]; p2 = pass[2]; end
         if (done[3] && t3 < 0) begin t3 = c; s3 = sig[3]; end
         if (done[4] && t4 < 0) begin t4 = c; s4 = sig[4]; end
         @(negedge clk);
      end
      check("one_done_cyc", 32'(t1), 32'd2);
      check("one_sig", 32'(s1), 32'h005A);
      check("two_done_cyc", 32'(t2), 32'd3);
      check("two_sig", 32'(s2), 32'h00EE);
      check("two_pass", 32'(p2), 32'(exp_p2));
      check("lat2_done_cyc", 32'(t3), 32'd19);
      check("lat2_sig", 32'(s3), 32'(exp16));
      check("lat0_done_cyc", 32'(t4), 32'd17);
      check("lat0_sig", 32'(s4), 32'(exp16));

      // Default configuration: seed, ignored start, completion
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      check("c1_stim", 32'(stim[0]), 32'hE1);
      check("c1_ena_busy", 32'({ena[0], busy[0], done[0]}), 32'b110);
      @(negedge clk);
      check("c2_stim", 32'(stim[0]), 32'hC3);
      repeat (7) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      check("ign_stim9", 32'(stim[0]), 32'(vec(9)));
      @(negedge clk);
      check("ign_stim10", 32'(stim[0]), 32'(vec(10)));
      run_to_done(11, t);
      check("run_done_cyc", 32'(t), 32'd258);
      check("run_sig", 32'(sig[0]), 32'(exp256));
      check("run_busy_low", 32'({busy[0], ena[0]}), 32'h0);
      check("run_pass", 32'(pass[0]), 32'(exp_p0));

      // Restart from DONE
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      check("rs_done_low", 32'(done[0]), 32'h0);
      check("rs_sig_clr", 32'(sig[0]), 32'h0);
      check("rs_stim", 32'(stim[0]), 32'hE1);
      run_to_done(1, t);
      check("rs_done_cyc", 32'(t), 32'd258);
      check("rs_sig", 32'(sig[0]), 32'(exp256));

      // Asynchronous reset mid-run, then a clean run
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (49) @(negedge clk);
      check("ar_busy_before", 32'(busy[0]), 32'h1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar_stim", 32'(stim[0]), 32'h0);
      check("ar_flags", 32'({ena[0], busy[0], done[0], pass[0]}), 32'h0);
      check("ar_sig", 32'(sig[0]), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      check("ar_c1_stim", 32'(stim[0]), 32'hE1);
      run_to_done(1, t);
      check("ar_done_cyc", 32'(t), 32'd258);
      check("ar_sig_final", 32'(sig[0]), 32'(exp256));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
